// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
// Circular free list of physical register indices for explicit renaming.
// Rename pops free registers from the speculative head. Commit pushes released
// registers back at the tail, and advances an architectural head so a flush can
// restore the speculative head in one cycle.
// Optional build macro: FREE_LIST_BYPASS_EN forwards a freed register straight
// to alloc_pd when the list is empty.
//
// Handshake: alloc_valid/alloc_pd is a valid/ready pair with dequeue as the
// ready side. A register is consumed only on a rising edge where
// alloc_valid && dequeue && !flush holds. alloc_pd is stable while alloc_valid
// is high and dequeue is low. Dequeue while alloc_valid is low has no effect.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REG = 40,
    parameter int NUM_ARCH_REG = 32,
    parameter int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG,
    parameter int PD_W         = $clog2(NUM_PHYS_REG),
    parameter int CNT_W        = $clog2(FL_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dequeue,
    output logic             alloc_valid,
    output logic [PD_W-1:0]  alloc_pd,
    input  logic             enqueue,
    input  logic [PD_W-1:0]  free_pd,
    input  logic             commit_adv,
    input  logic             flush,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FL_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FL_DEPTH);

    // Slot index plus wrap bit. Equal index with a different wrap bit means full.
    typedef struct packed {
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p.idx == LAST_IDX) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + 1'b1;
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    logic [PD_W-1:0] slot [FL_DEPTH];
    ptr_t            spec_head;
    ptr_t            arch_head;
    ptr_t            tail;

    logic spec_empty;
    logic full;
    logic free_nonzero;
    logic do_enq;
    logic do_deq;
    ptr_t arch_head_nxt;
    ptr_t spec_head_nxt;

    // Occupancy flags and the speculative count, derived purely from the pointers.
    always_comb begin
        spec_empty = (spec_head.idx == tail.idx) && (spec_head.wrap == tail.wrap);
        full       = (spec_head.idx == tail.idx) && (spec_head.wrap != tail.wrap);
        if (spec_head.wrap != tail.wrap) begin
            count = DEPTH_CNT - CNT_W'(spec_head.idx) + CNT_W'(tail.idx);
        end else begin
            count = CNT_W'(tail.idx) - CNT_W'(spec_head.idx);
        end
    end

    assign empty        = spec_empty;
    assign free_nonzero = (free_pd != '0);

`ifdef FREE_LIST_BYPASS_EN
    logic bypass_hit;

    // Offer the register being freed directly when the list has nothing to give.
    always_comb begin
        bypass_hit  = spec_empty && enqueue && free_nonzero;
        alloc_valid = !spec_empty || bypass_hit;
        alloc_pd    = bypass_hit ? free_pd : slot[spec_head.idx];
    end
`else
    // Allocation comes only from stored slots, so a freed register appears a cycle later.
    always_comb begin
        alloc_valid = !spec_empty;
        alloc_pd    = slot[spec_head.idx];
    end
`endif

    // Next-state pointer decisions. A flush restores from the post-commit architectural head.
    always_comb begin
        do_enq        = enqueue && free_nonzero && !full;
        do_deq        = dequeue && alloc_valid && !flush;
        arch_head_nxt = commit_adv ? ptr_inc(arch_head) : arch_head;
        if (flush) begin
            spec_head_nxt = arch_head_nxt;
        end else if (do_deq) begin
            spec_head_nxt = ptr_inc(spec_head);
        end else begin
            spec_head_nxt = spec_head;
        end
    end

    // Pointer registers. Reset leaves the list full, holding the registers above the architectural set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_head <= '0;
            arch_head <= '0;
            tail      <= '{wrap: 1'b1, idx: '0};
        end else begin
            spec_head <= spec_head_nxt;
            arch_head <= arch_head_nxt;
            if (do_enq) begin
                tail <= ptr_inc(tail);
            end
        end
    end

    // Slot storage. Each slot is reloaded with its reset register index and written on enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                slot[i] <= PD_W'(NUM_ARCH_REG + i);
            end
        end else if (do_enq) begin
            slot[tail.idx] <= free_pd;
        end
    end

    // Pushing into a full list means commit freed more registers than exist.
    enq_not_full_a: assert property (@(posedge clk) disable iff (rst)
        !(enqueue && free_nonzero && full));

    // The architectural head may only retire entries that rename has actually taken.
    arch_not_past_tail_a: assert property (@(posedge clk) disable iff (rst)
        !(commit_adv && (arch_head == tail)));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list
// Directed bench for phys_reg_free_list with 40 physical and 32 architectural
// registers, giving a depth of 8. Compile with FREE_LIST_BYPASS_EN defined to
// exercise the same-cycle forwarding path.
module tb_phys_reg_free_list;

    logic       clk;
    logic       rst;
    logic       dequeue;
    logic       alloc_valid;
    logic [5:0] alloc_pd;
    logic       enqueue;
    logic [5:0] free_pd;
    logic       commit_adv;
    logic       flush;
    logic       empty;
    logic [3:0] count;

    int total;
    int bad;

    phys_reg_free_list #(
        .NUM_PHYS_REG(40),
        .NUM_ARCH_REG(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dequeue    (dequeue),
        .alloc_valid(alloc_valid),
        .alloc_pd   (alloc_pd),
        .enqueue    (enqueue),
        .free_pd    (free_pd),
        .commit_adv (commit_adv),
        .flush      (flush),
        .empty      (empty),
        .count      (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        dequeue    = 1'b0;
        enqueue    = 1'b0;
        free_pd    = '0;
        commit_adv = 1'b0;
        flush      = 1'b0;
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic do_dequeues(input int n);
        dequeue = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        dequeue = 1'b0;
        #1;
    endtask

    // Driver tasks / scenarios
    task automatic test_reset();
        apply_reset();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL reset_count got=%0d want=8", count); end
        total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL reset_valid got=%b want=1", alloc_valid); end
        total++; if (alloc_pd !== 6'd32) begin bad++; $display("FAIL reset_pd got=%0d want=32", alloc_pd); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%b want=0", empty); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        do_dequeues(3);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_pre_count got=%0d want=5", count); end
        // Assert reset between edges; outputs must recover without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL mid_rst_count got=%0d want=8", count); end
        total++; if (alloc_pd !== 6'd32) begin bad++; $display("FAIL mid_rst_pd got=%0d want=32", alloc_pd); end
        total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_valid got=%b want=1", alloc_valid); end
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_drain_and_free();
        apply_reset();
        dequeue = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (alloc_pd !== 6'(32 + i)) begin bad++; $display("FAIL drain_pd[%0d] got=%0d want=%0d", i, alloc_pd, 32 + i); end
            cycle();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", alloc_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
        // Ninth dequeue on an empty list must change nothing.
        cycle();
        dequeue = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL ninth_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ninth_empty got=%b want=1", empty); end

        enqueue = 1'b1;
        free_pd = 6'd5;
`ifdef FREE_LIST_BYPASS_EN
        dequeue = 1'b1;
        #1;
        total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b want=1", alloc_valid); end
        total++; if (alloc_pd !== 6'd5) begin bad++; $display("FAIL byp_pd got=%0d want=5", alloc_pd); end
        cycle();
        idle_inputs();
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL byp_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL byp_empty got=%b want=1", empty); end
`else
        #1;
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL nobyp_valid got=%b want=0", alloc_valid); end
        cycle();
        idle_inputs();
        #1;
        total++; if (alloc_pd !== 6'd5) begin bad++; $display("FAIL free_pd_next got=%0d want=5", alloc_pd); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL free_count got=%0d want=1", count); end
        total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL free_valid got=%b want=1", alloc_valid); end
`endif
    endtask

    task automatic test_flush();
        apply_reset();
        do_dequeues(3);
        commit_adv = 1'b1;
        cycle();
        commit_adv = 1'b0;
        flush      = 1'b1;
        dequeue    = 1'b1;
        cycle();
        idle_inputs();
        #1;
        total++; if (alloc_pd !== 6'd33) begin bad++; $display("FAIL flush_pd got=%0d want=33", alloc_pd); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL flush_count got=%0d want=7", count); end
        // Flush with same-cycle commit and enqueue: head restores to post-commit arch head.
        do_dequeues(2);
        flush      = 1'b1;
        commit_adv = 1'b1;
        enqueue    = 1'b1;
        free_pd    = 6'd12;
        cycle();
        idle_inputs();
        #1;
        total++; if (alloc_pd !== 6'd34) begin bad++; $display("FAIL flush_commit_pd got=%0d want=34", alloc_pd); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL flush_commit_count got=%0d want=7", count); end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_seq [6];
        exp_seq = '{6'd38, 6'd39, 6'd1, 6'd2, 6'd3, 6'd4};
        apply_reset();
        do_dequeues(6);
        enqueue = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            free_pd = 6'(i);
            cycle();
        end
        idle_inputs();
        commit_adv = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        commit_adv = 1'b0;
        #1;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL wrap_full_count got=%0d want=8", count); end
        dequeue = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (alloc_pd !== exp_seq[i]) begin bad++; $display("FAIL wrap_pd[%0d] got=%0d want=%0d", i, alloc_pd, exp_seq[i]); end
            cycle();
        end
        dequeue = 1'b0;
        #1;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL wrap_end_count got=%0d want=2", count); end
        total++; if (alloc_pd !== 6'd5) begin bad++; $display("FAIL wrap_end_pd got=%0d want=5", alloc_pd); end
    endtask

    task automatic test_x0_guard();
        apply_reset();
        do_dequeues(4);
        enqueue = 1'b1;
        free_pd = 6'd0;
        cycle();
        idle_inputs();
        #1;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL x0_count got=%0d want=4", count); end
        dequeue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (alloc_pd !== 6'(36 + i)) begin bad++; $display("FAIL x0_pd[%0d] got=%0d want=%0d", i, alloc_pd, 36 + i); end
            cycle();
        end
        dequeue = 1'b0;
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL x0_empty got=%b want=1", empty); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_dequeues(2);
        enqueue = 1'b1;
        dequeue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            free_pd = 6'(9 + i);
            #1;
            total++;
            if (alloc_pd !== 6'(34 + i)) begin bad++; $display("FAIL b2b_pd[%0d] got=%0d want=%0d", i, alloc_pd, 34 + i); end
            cycle();
            total++;
            if (count !== 4'd6) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=6", i, count); end
        end
        idle_inputs();
        #1;
    endtask

    // Sequence and final report
    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_reset_midstream();
        test_drain_and_free();
        test_flush();
        test_wrap();
        test_x0_guard();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Parametrised circular free list of physical register indices for the out-of-order RV32I core's explicit-renaming scheme.
- Decode/rename pops a free `pd` for each instruction that writes a destination register. Commit pushes back the stale `pd` it has just released.
- A committed (architectural) head pointer is kept alongside the speculative head, so a flush restores the speculative allocation state in one cycle.

Parameters:
- NUM_PHYS_REG, 40, total physical registers; must be greater than NUM_ARCH_REG.
- NUM_ARCH_REG, 32, architectural registers; `p0..p(NUM_ARCH_REG-1)` are mapped at reset and never start in the list.
- FL_DEPTH, NUM_PHYS_REG-NUM_ARCH_REG, number of list slots; any value ≥1, not restricted to a power of two.
- PD_W, $clog2(NUM_PHYS_REG), width of a physical register index.
- CNT_W, $clog2(FL_DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- dequeue  in  1  rename allocates `alloc_pd` this cycle.
- alloc_valid  out  1  `alloc_pd` is valid (list non-empty, or bypass hit).
- alloc_pd  out  PD_W  next free physical register.
- enqueue  in  1  commit frees `free_pd` this cycle.
- free_pd  in  PD_W  physical register being freed.
- commit_adv  in  1  a committing instruction consumed a list entry (rd≠x0); advances the architectural head.
- flush  in  1  mispredict recovery: speculative head ← architectural head.
- empty  out  1  speculative occupancy is 0.
- count  out  CNT_W  speculative occupancy (tail minus speculative head, modulo the wrap).

Behaviour:
- Storage: FL_DEPTH × PD_W registers.
- Pointers: `spec_head`, `arch_head`, `tail`, each an index 0..FL_DEPTH-1 plus a wrap bit. Increment wraps from FL_DEPTH-1 to 0 and toggles the wrap bit.
- Reset (asynchronous, immediate, also mid-operation):
  - `slot[i] = NUM_ARCH_REG+i`.
  - `spec_head = arch_head = tail = 0`, with the tail wrap bit set (list full).
  - Outputs during reset: `count = FL_DEPTH`, `empty = 0`, `alloc_valid = 1`, `alloc_pd = NUM_ARCH_REG`.
- Outputs are combinational from state:
  - `alloc_pd = slot[spec_head]`.
  - `empty` = speculative-empty, i.e. pointers equal and wrap bits equal.
  - `alloc_valid = !empty`.
- Dequeue: if `dequeue && alloc_valid && !flush`, `spec_head` advances at the edge. Dequeue while `alloc_valid = 0` is ignored; no state change.
- Enqueue: if `enqueue && free_pd != 0`:
  - `slot[tail] ← free_pd`, then `tail` advances.
  - `free_pd = 0` is silently dropped (x0 is never renamed).
  - Enqueue while full is illegal; it is guarded by a simulation assertion, and the RTL drops the write.
- commit_adv: `arch_head` advances by 1. `arch_head` never passes `tail`; this is asserted in simulation.
- Flush:
  - `spec_head` ← next-state `arch_head`, including a same-cycle `commit_adv`.
  - Any same-cycle `dequeue` is ignored.
  - A same-cycle `enqueue` still writes and advances `tail`.
- Simultaneous enqueue + dequeue on a non-empty list: both occur and `count` is unchanged.
- Latency:
  - A freed `pd` is visible on `alloc_pd` no earlier than the cycle after the enqueue (no bypass, except under the optional feature).
  - After a flush, `count` and `alloc_pd` reflect the restored head in the next cycle.
- Full-wrap consistency: after any sequence of legal operations with no outstanding allocations (`spec_head == arch_head`), `count == FL_DEPTH`.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- When defined, and the list is empty while `enqueue && free_pd != 0`:
  - `alloc_valid = 1` and `alloc_pd = free_pd` in the same cycle.
  - A same-cycle `dequeue` consumes it: the slot is still written, and `tail` and `spec_head` both advance, so `arch_head` positional tracking stays consistent.
- When undefined: `alloc_valid = !empty` strictly; there is no same-cycle forwarding.

Test Plan (all with NUM_PHYS_REG=40, NUM_ARCH_REG=32, FL_DEPTH=8):
- Reset check: assert `rst`, release → `count = 8`, `alloc_valid = 1`, `alloc_pd = 32`; asserting `rst` mid-stream restores these immediately, without waiting for a clock edge.
- Drain: 8 consecutive dequeues → `alloc_pd` sequence 32..39; then `empty = 1`, `alloc_valid = 0`, `count = 0`; a 9th dequeue is ignored with no state change.
- Empty then free: after the drain, enqueue `free_pd = 5` → next cycle `alloc_pd = 5`, `count = 1`. With FREE_LIST_BYPASS_EN, `alloc_pd = 5` appears in the same cycle, and a same-cycle dequeue leaves `count = 0`.
- Flush recovery: from reset, dequeue 3 (32, 33, 34), then `commit_adv` once, then flush with a same-cycle dequeue → next cycle `alloc_pd = 33`, `count = 7`; the dequeue is ignored.
- Wrap-around: dequeue 6, enqueue 1, 2, 3, 4, 5, 6, commit_adv 6, dequeue 6 → `alloc_pd` sequence 38, 39, 1, 2, 3, 4; tail and head wrap bits toggle correctly.
- x0 guard: enqueue `free_pd = 0` on a list with `count = 4` → `count` stays 4 and the tail slot is unchanged.
